// File: rtl/bin_to_bcd_if.sv
// Handshake and result bus for the sequential binary-to-BCD converter.
// The master side issues start/bin_in. The slave side (the converter) returns
// busy, a one-cycle done pulse, and the packed BCD result.
interface bin_to_bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 ("double dabble").
// It drives active-low 7-segment digits (bit0=a .. bit6=g).
// One input bit is consumed per clock. The result and the HEX digits change only
// on the done edge, so the displays never show partial values while shifting.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks HEX digits above the most
// significant nonzero digit. HEX0 always shows a value, and bcd_out is unaffected.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic        CLOCK_50,
    input  logic        KEY0,
    bin_to_bcd_if.slave bus,
    output logic [0:6]  HEX0,
    output logic [0:6]  HEX1,
    output logic [0:6]  HEX2
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    // Three HEX outputs exist regardless of DIGITS. Pad so that a missing digit reads as blank.
    localparam int PD    = (DIGITS > 3) ? DIGITS : 3;

    localparam logic [0:6]       SEG_BLANK = 7'b1111111;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt;
    logic              busy_flag;
    logic              done_flag;
    logic [BCD_W-1:0]  bcd_hold;
    logic [BCD_W-1:0]  result;
    logic [4*PD-1:0]   res_pad;
    logic [PD-1:0]     show;
    logic [0:6]        hex_next0;
    logic [0:6]        hex_next1;
    logic [0:6]        hex_next2;

    // Active-low segment pattern for one BCD nibble. Non-decimal codes are blanked.
    function automatic logic [0:6] seg7(input logic [3:0] nib);
        logic [0:6] s;
        case (nib)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add-3 correction on every BCD nibble >= 5 before the next shift.
    // 4-bit add: no carry out is possible for nibbles 5..9.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[BIN_W + 4*d +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    // Once all bits are shifted, the BCD field sits at the top of the shift register.
    always_comb begin
        result                = sr[SR_W-1 -: BCD_W];
        res_pad               = '0;
        res_pad[BCD_W-1:0]    = result;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen;

    // Digit visibility. Show digit 0 always, and every digit from the top nonzero one down.
    always_comb begin
        seen = 1'b0;
        show = '0;
        for (int d = PD - 1; d >= 0; d--) begin
            if (d == 0 || res_pad[4*d +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            show[d] = seen && (d < DIGITS);
        end
    end
`else
    // Digit visibility. Every implemented digit is shown, leading zeros included.
    always_comb begin
        show = '0;
        for (int d = 0; d < PD; d++) begin
            show[d] = (d < DIGITS);
        end
    end
`endif

    // Segment patterns to be registered on the done edge.
    always_comb begin
        hex_next0 = show[0] ? seg7(res_pad[3:0])  : SEG_BLANK;
        hex_next1 = show[1] ? seg7(res_pad[7:4])  : SEG_BLANK;
        hex_next2 = show[2] ? seg7(res_pad[11:8]) : SEG_BLANK;
    end

    // Control FSM with registered busy/done/result/HEX outputs.
    // DONE spans two cycles. The first cycle latches the result and raises done.
    // The second cycle drops done and returns to IDLE. This keeps done a single
    // pulse, and a held start is accepted every BIN_W+3 clocks.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            busy_flag <= 1'b0;
            done_flag <= 1'b0;
            bcd_hold  <= '0;
            HEX0      <= SEG_BLANK;
            HEX1      <= SEG_BLANK;
            HEX2      <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    done_flag <= 1'b0;
                    if (bus.start) begin
                        sr        <= {{BCD_W{1'b0}}, bus.bin_in};
                        cnt       <= '0;
                        busy_flag <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!done_flag) begin
                        bcd_hold  <= result;
                        HEX0      <= hex_next0;
                        HEX1      <= hex_next1;
                        HEX2      <= hex_next2;
                        done_flag <= 1'b1;
                        busy_flag <= 1'b0;
                    end else begin
                        done_flag <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy_flag <= 1'b0;
                    done_flag <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_flag;
    assign bus.done    = done_flag;
    assign bus.bcd_out = bcd_hold;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3).
// Expected BCD/HEX values are computed from integer arithmetic and queued when a
// conversion is started. They are popped and compared on every done pulse.
module tb_bin_to_bcd_seq;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [0:6] hex0;
    logic [0:6] hex1;
    logic [0:6] hex2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];
    int mon_v;

    bin_to_bcd_if #(.BIN_W(8), .DIGITS(3)) bus();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .CLOCK_50 (clk),
        .KEY0     (rst_n),
        .bus      (bus),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [11:0] exp_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'((v) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic logic [0:6] seg_ref(input int n);
        logic [0:6] s;
        case (n)
            0: s = 7'b0000001;
            1: s = 7'b1001111;
            2: s = 7'b0010010;
            3: s = 7'b0000110;
            4: s = 7'b1001100;
            5: s = 7'b0100100;
            6: s = 7'b0100000;
            7: s = 7'b0001111;
            8: s = 7'b0000000;
            9: s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [0:6] exp_hex(input int v, input int d);
        int p;
        p = (d == 0) ? 1 : ((d == 1) ? 10 : 100);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p) return 7'b1111111;
`endif
        return seg_ref((v / p) % 10);
    endfunction

    // Scoreboard: every done pulse must match the oldest queued conversion.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got bcd_out=%h, required no done pulse", bus.bcd_out);
            end else begin
                mon_v = exp_q.pop_front();
                if (bus.bcd_out !== exp_bcd(mon_v)) begin
                    errors++;
                    $display("FAIL sb_bcd(%0d): got %h, required %h", mon_v, bus.bcd_out, exp_bcd(mon_v));
                end
                checks++;
                if (hex0 !== exp_hex(mon_v, 0)) begin
                    errors++;
                    $display("FAIL sb_hex0(%0d): got %b, required %b", mon_v, hex0, exp_hex(mon_v, 0));
                end
                checks++;
                if (hex1 !== exp_hex(mon_v, 1)) begin
                    errors++;
                    $display("FAIL sb_hex1(%0d): got %b, required %b", mon_v, hex1, exp_hex(mon_v, 1));
                end
                checks++;
                if (hex2 !== exp_hex(mon_v, 2)) begin
                    errors++;
                    $display("FAIL sb_hex2(%0d): got %b, required %b", mon_v, hex2, exp_hex(mon_v, 2));
                end
            end
        end
    end

    // Stimulus: one-cycle start pulse from an idle DUT. Returns at the negedge after E0.
    task automatic start_conv(input int v, input bit expect_result);
        logic [31:0] w;
        w = v;
        @(negedge clk);
        bus.bin_in = w[7:0];
        bus.start  = 1'b1;
        if (expect_result) exp_q.push_back(v);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Advance negedge by negedge until done is seen or the budget expires.
    task automatic wait_done(input int budget, output int waited, output bit seen);
        waited = 0;
        while (!bus.done && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        seen = bus.done;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b done=%b bcd=%h, required 0 0 000", bus.busy, bus.done, bus.bcd_out);
        end
        checks++;
        if (hex0 !== 7'b1111111 || hex1 !== 7'b1111111 || hex2 !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_hex: got %b %b %b, required all 1111111", hex2, hex1, hex0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift;
        int  w;
        bit  s;
        start_conv(200, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
            errors++;
            $display("FAIL midreset_ctrl: got busy=%b done=%b bcd=%h, required 0 0 000", bus.busy, bus.done, bus.bcd_out);
        end
        checks++;
        if (hex0 !== 7'b1111111 || hex1 !== 7'b1111111 || hex2 !== 7'b1111111) begin
            errors++;
            $display("FAIL midreset_hex: got %b %b %b, required all 1111111", hex2, hex1, hex0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_conv(42, 1'b1);
        wait_done(20, w, s);
        checks++;
        if (!s || bus.bcd_out !== 12'h042) begin
            errors++;
            $display("FAIL after_reset_42: got seen=%b bcd=%h, required 1 042", s, bus.bcd_out);
        end
        @(negedge clk);
    endtask

    task automatic test_max;
        int  k;
        int  nb;
        start_conv(255, 1'b1);
        k  = 0;
        nb = 0;
        while (!bus.done && k < 20) begin
            if (bus.busy) nb++;
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== 9 || nb !== 9) begin
            errors++;
            $display("FAIL max_latency: got done at E%0d busy_cycles=%0d, required E9 9", k, nb);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.bcd_out !== 12'h255) begin
            errors++;
            $display("FAIL max_value: got busy=%b bcd=%h, required 0 255", bus.busy, bus.bcd_out);
        end
        checks++;
        if (hex2 !== 7'b0010010 || hex1 !== 7'b0100100 || hex0 !== 7'b0100100) begin
            errors++;
            $display("FAIL max_hex: got %b %b %b, required 0010010 0100100 0100100", hex2, hex1, hex0);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL max_pulse_width: got done=%b, required 0", bus.done);
        end
    endtask

    task automatic test_zero;
        int  w;
        bit  s;
        logic [0:6] upper;
`ifdef LEADING_ZERO_BLANK_EN
        upper = 7'b1111111;
`else
        upper = 7'b0000001;
`endif
        start_conv(0, 1'b1);
        wait_done(20, w, s);
        checks++;
        if (!s || bus.bcd_out !== 12'h000 || hex0 !== 7'b0000001) begin
            errors++;
            $display("FAIL zero_value: got seen=%b bcd=%h hex0=%b, required 1 000 0000001", s, bus.bcd_out, hex0);
        end
        checks++;
        if (hex1 !== upper || hex2 !== upper) begin
            errors++;
            $display("FAIL zero_upper_hex: got %b %b, required %b %b", hex2, hex1, upper, upper);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int ndone;
        logic [11:0] last;
        start_conv(99, 1'b1);
        repeat (3) @(negedge clk);
        bus.bin_in = 8'd200;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        ndone = 0;
        last  = 12'hfff;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                ndone++;
                last = bus.bcd_out;
            end
            @(negedge clk);
        end
        checks++;
        if (ndone !== 1 || last !== 12'h099) begin
            errors++;
            $display("FAIL ignore_start: got %0d done pulses bcd=%h, required 1 099", ndone, last);
        end
    endtask

    task automatic test_held_start;
        int  w;
        bit  s;
        int  t[3];
        int  stray;
        @(negedge clk);
        bus.bin_in = 8'd128;
        bus.start  = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(128);
        for (int p = 0; p < 3; p++) begin
            wait_done(25, w, s);
            t[p] = cyc;
            checks++;
            if (!s || bus.bcd_out !== 12'h128) begin
                errors++;
                $display("FAIL held_done%0d: got seen=%b bcd=%h, required 1 128", p, s, bus.bcd_out);
            end
            if (p == 2) bus.start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (t[1] - t[0] !== 11 || t[2] - t[1] !== 11) begin
            errors++;
            $display("FAIL held_period: got %0d %0d, required 11 11", t[1] - t[0], t[2] - t[1]);
        end
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL held_stray: got %0d extra done pulses, required 0", stray);
        end
    endtask

    task automatic test_sweep;
        int w;
        bit s;
        for (int v = 0; v < 256; v++) begin
            start_conv(v, 1'b1);
            wait_done(20, w, s);
            checks++;
            if (!s) begin
                errors++;
                $display("FAIL sweep_timeout(%0d): got no done in %0d cycles, required done", v, w);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start  = 1'b0;
        bus.bin_in = 8'd0;
        test_reset;
        test_reset_mid_shift;
        test_max;
        test_zero;
        test_ignore_start;
        test_held_start;
        test_sweep;
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
